// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: divider state encoding,
// iteration count and the divide-by-zero quotient pattern.
package mdu_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITER  = DIV_WIDTH;

  // Quotient magnitude produced by the restoring algorithm when the divisor is zero
  localparam logic [DIV_WIDTH-1:0] DIV_RESULT_ZERO_Q = '1;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift {rem, quo} left by one,
// trial-subtract the divisor and record the outcome in the quotient LSB.
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shifted;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  // The shifted remainder needs one extra bit so the compare never overflows
  assign w_shifted = {i_rem, i_quo[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, i_divisor};
  assign w_fits    = (w_shifted >= {1'b0, i_divisor});

  assign o_rem = w_fits ? w_diff[WIDTH-1:0] : w_shifted[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_fits};

endmodule

// File: rtl/mdu_div_iter.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU (LO = quotient,
// HI = remainder). Stalls the pipeline while iterating and holds its result
// while the memory side freezes the pipeline.
// Optional feature macro: DIV_EARLY_OUT_EN (finish in one cycle when the
// divisor is zero or |dividend| < |divisor|).
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  input  logic             stall_ext,
  output logic             div_stall,
  output logic             result_valid,
  output logic [WIDTH-1:0] lo_out,
  output logic [WIDTH-1:0] hi_out
);

  div_state_e       r_state;
  div_state_e       w_next_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_hi;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;
  logic             w_last;
  logic             w_early;

  // Negate a magnitude when the result must be negative
  function automatic logic [WIDTH-1:0] fixSign(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  // The unsigned path never takes magnitudes, so DIVU operands pass straight through
  assign w_dvd_neg = signed_div & dividend[WIDTH-1];
  assign w_dvs_neg = signed_div & divisor[WIDTH-1];
  assign w_dvd_abs = w_dvd_neg ? -dividend : dividend;
  assign w_dvs_abs = w_dvs_neg ? -divisor : divisor;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_dvs_abs == '0) || (w_dvd_abs < w_dvs_abs);
`else
  assign w_early = 1'b0;
`endif

  div_restore_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_div),
    .o_rem    (w_step_rem),
    .o_quo    (w_step_quo)
  );

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= DIV_IDLE;
    else         r_state <= w_next_state;
  end

  // Next-state decode plus the combinational stall that freezes EX from the first cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      DIV_IDLE: if (start)      w_next_state = w_early ? DIV_DONE : DIV_BUSY;
      DIV_BUSY: if (w_last)     w_next_state = DIV_DONE;
      DIV_DONE: if (!stall_ext) w_next_state = DIV_IDLE;
      default:                  w_next_state = DIV_IDLE;
    endcase
    if (flush) w_next_state = DIV_IDLE;
    result_valid = (r_state == DIV_DONE);
    div_stall    = (((r_state == DIV_IDLE) && start) || (r_state == DIV_BUSY)) && !flush;
  end

  // Operand capture, one restoring step per BUSY cycle and sign fix-up on the last step
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_lo    <= '0;
      r_hi    <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (!flush) begin
      case (r_state)
        DIV_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= w_dvd_abs;
            r_div   <= w_dvs_abs;
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
`ifdef DIV_EARLY_OUT_EN
            if (w_early) begin
              r_lo <= fixSign((w_dvs_abs == '0) ? WIDTH'(DIV_RESULT_ZERO_Q) : '0,
                              w_dvd_neg ^ w_dvs_neg);
              r_hi <= fixSign(w_dvd_abs, w_dvd_neg);
            end
`endif
          end
        end
        DIV_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          if (w_last) begin
            r_lo <= fixSign(w_step_quo, r_neg_q);
            r_hi <= fixSign(w_step_rem, r_neg_r);
          end
        end
        default: ;
      endcase
    end
  end

  assign lo_out = r_lo;
  assign hi_out = r_hi;

endmodule
